bipi_program_loader: RTL

Serial program loader for the BIPI processor: takes a byte stream from the UART receiver, builds 16-bit instruction words (5-bit opcode, 11-bit operand), and writes them into program memory from address 0 upward. It stops after the HALT instruction and then releases the CPU from reset. It produces exactly the words the instruction decoder will fetch, and it is the only writer of program memory.

---
 rtl/bipi_pkg.sv | 36 +++
 rtl/loader_checksum.sv | 29 ++
 rtl/bipi_program_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bipi_pkg.sv
// Shared BIPI definitions: instruction field layout, widths and opcodes.
// Used by the program loader and the instruction decoder so both agree on
// the word format.
package bipi_pkg;

    localparam int OPCODE_LENGTH    = 5;
    localparam int OPERAND_LENGTH   = 11;
    localparam int INSTR_WIDTH      = 16;
    localparam int BYTE_WIDTH       = 8;
    localparam int PROG_ADDR_LENGTH = 11;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 11;
    localparam int OPERAND_MSB = 10;
    localparam int OPERAND_LSB = 0;

    // Position of the opcode field inside the high byte of a word.
    localparam int HI_OPCODE_LSB = OPCODE_LSB - BYTE_WIDTH;

    typedef logic [OPCODE_LENGTH-1:0] opcode_t;

    localparam opcode_t OP_HALT = 5'b00000;
    localparam opcode_t OP_STO  = 5'b00001;
    localparam opcode_t OP_LD   = 5'b00010;
    localparam opcode_t OP_LDI  = 5'b00011;
    localparam opcode_t OP_ADD  = 5'b00100;
    localparam opcode_t OP_ADDI = 5'b00101;
    localparam opcode_t OP_SUB  = 5'b00110;
    localparam opcode_t OP_SUBI = 5'b00111;

    // True when the high byte of a word carries the HALT opcode.
    function automatic logic is_halt_hi(input logic [BYTE_WIDTH-1:0] hi);
        return hi[BYTE_WIDTH-1:HI_OPCODE_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running mod-256 sum over program bytes, with clear and compare.
// Only instantiated when BIPI_LOADER_CHECKSUM_EN is defined.
module loader_checksum
    import bipi_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic                  o_match
);

    logic [BYTE_WIDTH-1:0] r_sum;

    // Accumulate each program byte; clear at the start of a load.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_match = (r_sum == i_byte);

endmodule

// File: rtl/bipi_program_loader.sv
// Serial program loader: assembles high/low UART bytes into 16-bit words,
// writes them to program memory from address 0, stops at HALT and then
// releases the CPU from reset.
// Optional: define BIPI_LOADER_CHECKSUM_EN to require a trailing mod-256
// checksum byte after HALT before the CPU is released.
//
// state   | meaning
// IDLE    | waiting for i_start
// LOAD_HI | waiting for the high byte (opcode + operand[10:8])
// LOAD_LO | waiting for the low byte; writes the word on arrival
// CHECK   | waiting for the checksum byte (checksum build only)
// DONE    | program loaded, CPU running
// ERROR   | memory full without HALT, or checksum mismatch
module bipi_program_loader
    import bipi_pkg::*;
#(
    parameter int ADDR_LENGTH = PROG_ADDR_LENGTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [BYTE_WIDTH-1:0]  i_rx_data,
    input  logic                   i_rx_valid,
    input  logic                   i_start,
    output logic                   o_wr_en,
    output logic [ADDR_LENGTH-1:0] o_wr_addr,
    output logic [INSTR_WIDTH-1:0] o_wr_data,
    output logic [ADDR_LENGTH:0]   o_word_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic                   o_cpu_reset
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
`ifdef BIPI_LOADER_CHECKSUM_EN
        S_CHECK   = 3'd3,
`endif
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam logic [ADDR_LENGTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_LENGTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_LENGTH:0]   COUNT_ONE = 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_start_load;
    logic                    w_accept_hi;
    logic                    w_write;
    logic [BYTE_WIDTH-1:0]   r_hi;
    logic [ADDR_LENGTH-1:0]  r_addr;
    logic [ADDR_LENGTH:0]    r_word_count;
    logic                    r_wr_en;
    logic [ADDR_LENGTH-1:0]  r_wr_addr;
    logic [INSTR_WIDTH-1:0]  r_wr_data;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_cpu_reset;

`ifdef BIPI_LOADER_CHECKSUM_EN
    logic w_chk_add;
    logic w_chk_match;

    assign w_chk_add = i_rx_valid && (r_state == S_LOAD_HI || r_state == S_LOAD_LO);

    loader_checksum u_checksum (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_start_load),
        .i_add   (w_chk_add),
        .i_byte  (i_rx_data),
        .o_match (w_chk_match)
    );
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle datapath controls.
    always_comb begin
        w_state_next = r_state;
        w_start_load = 1'b0;
        w_accept_hi  = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_start_load = 1'b1;
                    w_state_next = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                if (i_rx_valid) begin
                    w_accept_hi  = 1'b1;
                    w_state_next = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                if (i_rx_valid) begin
                    w_write = 1'b1;
                    if (is_halt_hi(r_hi)) begin
`ifdef BIPI_LOADER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_state_next = S_DONE;
`endif
                    end else if (r_addr == ADDR_LAST) begin
                        w_state_next = S_ERROR;
                    end else begin
                        w_state_next = S_LOAD_HI;
                    end
                end
            end
`ifdef BIPI_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (i_rx_valid) begin
                    w_state_next = w_chk_match ? S_DONE : S_ERROR;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Word assembly, address/count tracking and the registered write port.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hi         <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_start_load) begin
                r_addr       <= '0;
                r_word_count <= '0;
            end
            if (w_accept_hi) begin
                r_hi <= i_rx_data;
            end
            if (w_write) begin
                r_wr_addr    <= r_addr;
                r_wr_data    <= {r_hi, i_rx_data};
                r_addr       <= r_addr + ADDR_ONE;
                r_word_count <= r_word_count + COUNT_ONE;
            end
        end
    end

    // Status flags track the state one cycle late, so the CPU is released
    // only after the HALT write strobe has completed.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
`ifdef BIPI_LOADER_CHECKSUM_EN
            r_busy      <= (r_state == S_LOAD_HI) || (r_state == S_LOAD_LO) || (r_state == S_CHECK);
`else
            r_busy      <= (r_state == S_LOAD_HI) || (r_state == S_LOAD_LO);
`endif
            r_done      <= (r_state == S_DONE);
            r_error     <= (r_state == S_ERROR);
            r_cpu_reset <= (r_state != S_DONE);
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_word_count = r_word_count;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_cpu_reset  = r_cpu_reset;

endmodule
